// File: rtl/fft4_butterfly_if.sv
// Streaming bus for the 4-point FFT butterfly: sample input side and bin output side.
interface fft4_butterfly_if;
   logic [31:0] din_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] dout_o;
   logic        valid_o;
   logic        ready_i;
   logic        done_flag_o;

   modport slave (
      input  din_i, valid_i, ready_i,
      output ready_o, dout_o, valid_o, done_flag_o
   );

   modport master (
      output din_i, valid_i, ready_i,
      input  ready_o, dout_o, valid_o, done_flag_o
   );
endinterface

// File: rtl/fft4_butterfly.sv
// Radix-2 4-point FFT on a bit-reversed input frame; results stream out in natural order.
// Define FFT4_STAGE_SCALE_EN to halve every stage result (1/4 gain); otherwise results wrap to 16 bits.
module fft4_butterfly (
   input  logic              clk,
   input  logic              rst_ni,
   fft4_butterfly_if.slave   bus
);

   typedef enum logic [1:0] {LOAD, STAGE1, STAGE2, OUT} state_t;

   state_t      state_q, state_d;
   logic [31:0] smp_q [4];
   logic [1:0]  slot_q;
   logic [1:0]  bin_q;
   logic [1:0]  nextBin;
   logic [31:0] dout_q;
   logic        done_q;
   logic        readyEn_q;
   logic        accept;
   logic        emit;
   logic [31:0] st1 [4];
   logic [31:0] st2 [4];

   // One component add/sub, evaluated in 17 bits before narrowing back to 16.
   function automatic logic [15:0] stageOp(input logic [15:0] x, input logic [15:0] y,
                                           input logic sub);
      logic [16:0] r;
      r = sub ? ({x[15], x} - {y[15], y}) : ({x[15], x} + {y[15], y});
`ifdef FFT4_STAGE_SCALE_EN
      return r[16:1];
`else
      return r[15:0];
`endif
   endfunction

   assign accept       = bus.valid_i && bus.ready_o;
   assign emit         = bus.valid_o && bus.ready_i;
   assign nextBin      = bin_q + 2'd1;
   assign bus.ready_o  = readyEn_q && (state_q == LOAD);
   assign bus.valid_o  = (state_q == OUT);
   assign bus.dout_o   = dout_q;
   assign bus.done_flag_o = done_q;

   // Slots hold x0, x2, x1, x3, so the first stage pairs neighbouring slots.
   assign st1[0] = {stageOp(smp_q[0][31:16], smp_q[1][31:16], 1'b0),
                    stageOp(smp_q[0][15:0],  smp_q[1][15:0],  1'b0)};
   assign st1[1] = {stageOp(smp_q[0][31:16], smp_q[1][31:16], 1'b1),
                    stageOp(smp_q[0][15:0],  smp_q[1][15:0],  1'b1)};
   assign st1[2] = {stageOp(smp_q[2][31:16], smp_q[3][31:16], 1'b0),
                    stageOp(smp_q[2][15:0],  smp_q[3][15:0],  1'b0)};
   assign st1[3] = {stageOp(smp_q[2][31:16], smp_q[3][31:16], 1'b1),
                    stageOp(smp_q[2][15:0],  smp_q[3][15:0],  1'b1)};

   // Twiddle -j swaps a3's components and negates the new imaginary part.
   assign st2[0] = {stageOp(smp_q[0][31:16], smp_q[2][31:16], 1'b0),
                    stageOp(smp_q[0][15:0],  smp_q[2][15:0],  1'b0)};
   assign st2[1] = {stageOp(smp_q[1][31:16], smp_q[3][15:0],  1'b0),
                    stageOp(smp_q[1][15:0],  smp_q[3][31:16], 1'b1)};
   assign st2[2] = {stageOp(smp_q[0][31:16], smp_q[2][31:16], 1'b1),
                    stageOp(smp_q[0][15:0],  smp_q[2][15:0],  1'b1)};
   assign st2[3] = {stageOp(smp_q[1][31:16], smp_q[3][15:0],  1'b1),
                    stageOp(smp_q[1][15:0],  smp_q[3][31:16], 1'b0)};

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (accept && (slot_q == 2'd3)) state_d = STAGE1;
         STAGE1:  state_d = STAGE2;
         STAGE2:  state_d = OUT;
         OUT:     if (emit && (bin_q == 2'd3)) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // The sample registers are reused in place: samples, then stage-1 results, then bins.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) smp_q[i] <= '0;
         slot_q    <= '0;
         bin_q     <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         readyEn_q <= 1'b0;
      end else begin
         readyEn_q <= 1'b1;
         done_q    <= emit && (bin_q == 2'd3);
         case (state_q)
            LOAD: begin
               if (accept) begin
                  smp_q[slot_q] <= bus.din_i;
                  slot_q        <= slot_q + 2'd1;
               end
            end
            STAGE1: begin
               for (int i = 0; i < 4; i++) smp_q[i] <= st1[i];
            end
            STAGE2: begin
               for (int i = 0; i < 4; i++) smp_q[i] <= st2[i];
               dout_q <= st2[0];
               bin_q  <= '0;
            end
            OUT: begin
               if (emit) begin
                  bin_q <= nextBin;
                  if (bin_q != 2'd3) dout_q <= smp_q[nextBin];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft4_butterfly.sv
// Randomized and directed bench for fft4_butterfly against a radix-2 DFT reference model.
module tb_fft4_butterfly;

   typedef logic [31:0] frame_t [4];

   logic clk;
   logic rst_ni;
   int   errorCount = 0;
   int   checkCount = 0;

   fft4_butterfly_if bus();

   fft4_butterfly dut (
      .clk    (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Stage narrowing: halve with floor when scaling, otherwise two's-complement wrap.
   function automatic int stageNarrow(input int v);
      int w;
`ifdef FFT4_STAGE_SCALE_EN
      return v >>> 1;
`else
      w = v & 32'h0000_FFFF;
      if (w >= 32768) w = w - 65536;
      return w;
`endif
   endfunction

   function automatic logic [31:0] packBin(input int re, input int im);
      logic [15:0] r16;
      logic [15:0] i16;
      r16 = re[15:0];
      i16 = im[15:0];
      return {r16, i16};
   endfunction

   // Decimation in time over natural-order x: even DFT E, odd DFT O, X[k] = E + W^k O.
   function automatic frame_t refDft(input frame_t x);
      int xr [4];
      int xi [4];
      int er0, ei0, er1, ei1, or0, oi0, or1, oi1;
      frame_t y;
      for (int n = 0; n < 4; n++) begin
         xr[n] = int'($signed(x[n][31:16]));
         xi[n] = int'($signed(x[n][15:0]));
      end
      er0 = stageNarrow(xr[0] + xr[2]);  ei0 = stageNarrow(xi[0] + xi[2]);
      er1 = stageNarrow(xr[0] - xr[2]);  ei1 = stageNarrow(xi[0] - xi[2]);
      or0 = stageNarrow(xr[1] + xr[3]);  oi0 = stageNarrow(xi[1] + xi[3]);
      or1 = stageNarrow(xr[1] - xr[3]);  oi1 = stageNarrow(xi[1] - xi[3]);
      y[0] = packBin(stageNarrow(er0 + or0), stageNarrow(ei0 + oi0));
      y[2] = packBin(stageNarrow(er0 - or0), stageNarrow(ei0 - oi0));
      y[1] = packBin(stageNarrow(er1 + oi1), stageNarrow(ei1 - or1));
      y[3] = packBin(stageNarrow(er1 - oi1), stageNarrow(ei1 + or1));
      return y;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic sendSample(input logic [31:0] d);
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      bus.din_i   = d;
      bus.valid_i = 1'b1;
      while (!bus.ready_o && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!bus.ready_o) checkOutput("readyTimeout", {31'b0, bus.ready_o}, 32'd1);
      @(posedge clk);
   endtask

   // Upstream delivers the frame bit-reversed: x0, x2, x1, x3.
   task automatic applyStimulus(input frame_t x);
      sendSample(x[0]);
      sendSample(x[2]);
      sendSample(x[1]);
      sendSample(x[3]);
   endtask

   task automatic runFrame(input frame_t x, input frame_t expv, input int stallBin,
                           input int stallLen);
      applyStimulus(x);
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.din_i   = $urandom;
      checkOutput("latency1Valid", {31'b0, bus.valid_o}, 32'd0);
      checkOutput("busyReady", {31'b0, bus.ready_o}, 32'd0);
      @(negedge clk);
      bus.din_i = $urandom;
      checkOutput("latency2Valid", {31'b0, bus.valid_o}, 32'd0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k == stallBin) begin
            bus.ready_i = 1'b0;
            repeat (stallLen) begin
               checkOutput($sformatf("stallValid%0d", k), {31'b0, bus.valid_o}, 32'd1);
               checkOutput($sformatf("stallHold%0d", k), bus.dout_o, expv[k]);
               @(negedge clk);
            end
         end
         bus.ready_i = 1'b1;
         checkOutput($sformatf("binValid%0d", k), {31'b0, bus.valid_o}, 32'd1);
         checkOutput($sformatf("binData%0d", k), bus.dout_o, expv[k]);
         checkOutput($sformatf("doneEarly%0d", k), {31'b0, bus.done_flag_o}, 32'd0);
         if (k == 3) bus.valid_i = 1'b0;
         @(negedge clk);
      end
      bus.ready_i = 1'b0;
      checkOutput("donePulse", {31'b0, bus.done_flag_o}, 32'd1);
      checkOutput("readyAfterFrame", {31'b0, bus.ready_o}, 32'd1);
      checkOutput("validAfterFrame", {31'b0, bus.valid_o}, 32'd0);
      checkOutput("doutHeld", bus.dout_o, expv[3]);
      @(negedge clk);
      checkOutput("doneSingle", {31'b0, bus.done_flag_o}, 32'd0);
   endtask

   initial begin
      frame_t x;
      frame_t expv;

      rst_ni      = 1'b0;
      bus.din_i   = '0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      #12;
      checkOutput("rstReady", {31'b0, bus.ready_o}, 32'd0);
      checkOutput("rstValid", {31'b0, bus.valid_o}, 32'd0);
      checkOutput("rstDout", bus.dout_o, 32'd0);
      checkOutput("rstDone", {31'b0, bus.done_flag_o}, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      #1;
      checkOutput("readyBeforeEdge", {31'b0, bus.ready_o}, 32'd0);
      @(negedge clk);
      checkOutput("readyAfterEdge", {31'b0, bus.ready_o}, 32'd1);

      // Impulse
      x = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
`ifdef FFT4_STAGE_SCALE_EN
      expv = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000};
`else
      expv = refDft(x);
`endif
      runFrame(x, expv, 4, 0);

      // DC
      x = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
`ifdef FFT4_STAGE_SCALE_EN
      expv = '{32'h2000_0000, 32'h0, 32'h0, 32'h0};
`else
      expv = refDft(x);
`endif
      runFrame(x, expv, 4, 0);

      // x1 only, with five cycles of backpressure on X1
      x = '{32'h0, 32'h4000_0000, 32'h0, 32'h0};
`ifdef FFT4_STAGE_SCALE_EN
      expv = '{32'h1000_0000, 32'h0000_F000, 32'hF000_0000, 32'h0000_1000};
`else
      expv = refDft(x);
`endif
      runFrame(x, expv, 1, 5);

      // Near full-scale DC exercises wrap (unscaled) or headroom (scaled)
      x = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
`ifdef FFT4_STAGE_SCALE_EN
      expv = refDft(x);
`else
      expv = '{32'hFFFC_0000, 32'h0, 32'h0, 32'h0};
`endif
      runFrame(x, expv, 4, 0);

      for (int f = 0; f < 8; f++) begin
         for (int n = 0; n < 4; n++) x[n] = $urandom;
         runFrame(x, refDft(x), int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
      end

      // Reset in the middle of a frame; dout holds the last random X3 until then
      sendSample(32'h1234_5678);
      sendSample(32'h9ABC_DEF0);
      @(negedge clk);
      bus.valid_i = 1'b0;
      rst_ni      = 1'b0;
      #1;
      checkOutput("midRstReady", {31'b0, bus.ready_o}, 32'd0);
      checkOutput("midRstValid", {31'b0, bus.valid_o}, 32'd0);
      checkOutput("midRstDout", bus.dout_o, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      #1;
      checkOutput("midRstReadyHeld", {31'b0, bus.ready_o}, 32'd0);
      x = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
`ifdef FFT4_STAGE_SCALE_EN
      expv = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000};
`else
      expv = refDft(x);
`endif
      runFrame(x, expv, 2, 3);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fft4_butterfly.md
FFT4_BUTTERFLY -- requirements
Module: fft4_butterfly

Interface
REQ-001 SHALL provide `clk`, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 SHALL provide `rst_ni`, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL provide `din_i`, input, 32 bits, input sample packed as {re[31:16], im[15:0]}, both signed Q1.15.
REQ-004 SHALL provide `valid_i`, input, 1 bit, input sample valid.
REQ-005 SHALL provide `ready_o`, output, 1 bit, block can accept an input sample.
REQ-006 SHALL provide `dout_o`, output, 32 bits, output bin, same packing as `din_i`.
REQ-007 SHALL provide `valid_o`, output, 1 bit, `dout_o` holds a valid bin.
REQ-008 SHALL provide `ready_i`, input, 1 bit, consumer accepts `dout_o`.
REQ-009 SHALL provide `done_flag_o`, output, 1 bit, one-cycle pulse on the cycle after the last bin of a frame is accepted.

Function
REQ-010 SHALL consume 4-sample frames delivered in bit-reversed order (slot0=x0, slot1=x2, slot2=x1, slot3=x3), i.e. the output order of the upstream bit-reversal stage.
REQ-011 SHALL accept an input sample on every rising edge where `valid_i` and `ready_o` are both high, and ignore `din_i` otherwise.
REQ-012 SHALL implement the FSM LOAD -> STAGE1 -> STAGE2 -> OUT -> LOAD.
REQ-013 SHALL drive `ready_o` high only in LOAD, and leave LOAD on the edge that accepts slot3.
REQ-014 SHALL, in STAGE1 (one cycle), compute a0=s0+s1, a1=s0-s1, a2=s2+s3, a3=s2-s3 component-wise.
REQ-015 SHALL, in STAGE2 (one cycle), compute X0=a0+a2, X2=a0-a2, X1=a1+t, X3=a1-t, where t=(-j)*a3 = {re=a3.im, im=-a3.re}.
REQ-016 SHALL perform every add/subtract in 17 bits; then scale or wrap the result to 16 bits per REQ-026/027.
REQ-017 SHALL hold `valid_o` high in OUT, presenting X0, X1, X2, X3 in natural order, with the first bin valid 2 cycles after the edge that accepted slot3.
REQ-018 SHALL advance to the next bin only on an edge where `valid_o` and `ready_i` are both high, and hold `dout_o` stable while `ready_i` is low (unbounded backpressure).
REQ-019 SHALL return to LOAD on the edge that accepts X3, with `ready_o` high in the following cycle, and pulse `done_flag_o` for exactly that cycle.
REQ-020 SHALL, outside OUT, hold `dout_o` at the last driven value and `valid_o` low.
REQ-021 SHALL handle the case where `valid_i` is asserted while not in LOAD: the sample is not accepted and no state changes.

Reset
REQ-022 SHALL, on `rst_ni` low, immediately clear state to LOAD, the slot counter and bin index to 0, and all sample registers to 0.
REQ-023 SHALL hold these reset output values: `ready_o`=0 while `rst_ni` is low and 1 from the first edge after release; `valid_o`=0; `dout_o`=0; `done_flag_o`=0.
REQ-024 SHALL, on reset mid-frame (any state), discard the partial frame; the next accepted sample is slot0.

Configuration
REQ-025 SHALL use the macro `FFT4_STAGE_SCALE_EN`.
REQ-026 SHALL, when `FFT4_STAGE_SCALE_EN` is defined, arithmetically shift each 17-bit stage result right by 1 (truncation), giving 1/4 overall gain and no overflow.
REQ-027 SHALL, when `FFT4_STAGE_SCALE_EN` is not defined, keep the low 16 bits of each stage result (two's-complement wrap, unity gain).

Verification (`FFT4_STAGE_SCALE_EN` defined unless noted)
REQ-028 SHALL cover an impulse: inputs 0x4000_0000, 0, 0, 0 -> dout_o 0x1000_0000 ×4, `done_flag_o` pulse once.
REQ-029 SHALL cover DC: four inputs of 0x2000_0000 -> X0=0x2000_0000, X1=X2=X3=0x0000_0000.
REQ-030 SHALL cover x1 only: inputs 0, 0, 0x4000_0000 (slot2), 0 -> X0=0x1000_0000, X1=0x0000_F000, X2=0xF000_0000, X3=0x0000_1000.
REQ-031 SHALL cover backpressure: `ready_i` low for 5 cycles during X1 -> X1 held stable, no bin lost or duplicated, first bin appears 2 cycles after slot3.
REQ-032 SHALL cover reset mid-frame: `rst_ni` pulsed low after 2 samples, then a full impulse frame -> impulse results of REQ-028 exactly.
REQ-033 SHALL cover the macro undefined: inputs 0x7FFF_0000 ×4 -> X0 re=0xFFFC (wrapped), X1=X2=X3=0.
